// File: rtl/audio_pkg.sv
// Shared types, note frequencies and tune tables for the square-wave melody player.
// Each ROM entry is {freq[11:0] in Hz, dur[15:0] in ticks, last}.
package audio_pkg;

    typedef struct packed {
        logic [11:0] freq;
        logic [15:0] dur;
        logic        last;
    } note_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PLAY,
        ST_GAP
    } player_state_e;

    localparam logic [11:0] REST = 12'd0;
    localparam logic [11:0] A4   = 12'd440;
    localparam logic [11:0] B4   = 12'd494;
    localparam logic [11:0] C5   = 12'd523;
    localparam logic [11:0] D5   = 12'd587;
    localparam logic [11:0] E5   = 12'd659;
    localparam logic [11:0] F5   = 12'd698;
    localparam logic [11:0] G5   = 12'd784;
    localparam logic [11:0] A5   = 12'd880;
    localparam logic [11:0] C6   = 12'd1047;

    localparam note_t NOTE_END = '{freq: 12'd0, dur: 16'd0, last: 1'b1};

    localparam int TUNE0_LEN = 23;
    localparam int TUNE1_LEN = 3;
    localparam int TUNE2_LEN = 4;
    localparam int TUNE3_LEN = 4;

    // Game over: slow descending phrase with rests.
    localparam note_t TUNE0 [TUNE0_LEN] = '{
        {E5,   16'd500,  1'b0}, {B4,   16'd250,  1'b0}, {C5,   16'd250,  1'b0},
        {D5,   16'd500,  1'b0}, {C5,   16'd250,  1'b0}, {B4,   16'd250,  1'b0},
        {A4,   16'd500,  1'b0}, {REST, 16'd250,  1'b0}, {A4,   16'd250,  1'b0},
        {C5,   16'd250,  1'b0}, {E5,   16'd500,  1'b0}, {D5,   16'd250,  1'b0},
        {C5,   16'd250,  1'b0}, {B4,   16'd750,  1'b0}, {C5,   16'd250,  1'b0},
        {D5,   16'd500,  1'b0}, {E5,   16'd500,  1'b0}, {C5,   16'd500,  1'b0},
        {A4,   16'd500,  1'b0}, {REST, 16'd250,  1'b0}, {A4,   16'd500,  1'b0},
        {B4,   16'd250,  1'b0}, {A4,   16'd1000, 1'b1}
    };

    // Line clear.
    localparam note_t TUNE1 [TUNE1_LEN] = '{
        {C5, 16'd3, 1'b0}, {E5, 16'd3, 1'b0}, {G5, 16'd4, 1'b1}
    };

    // Level up.
    localparam note_t TUNE2 [TUNE2_LEN] = '{
        {C5, 16'd2, 1'b0}, {E5, 16'd2, 1'b0}, {G5, 16'd2, 1'b0}, {C6, 16'd4, 1'b1}
    };

    // Tetris: contains a rest and a zero-length entry that is skipped.
    localparam note_t TUNE3 [TUNE3_LEN] = '{
        {E5, 16'd2, 1'b0}, {REST, 16'd3, 1'b0}, {A5, 16'd0, 1'b0}, {C6, 16'd2, 1'b1}
    };

endpackage

// File: rtl/tune_rom.sv
// Combinational tune lookup: (tune_id, note_idx) -> note_t.
// Any lookup past the end of a tune or past the last tune returns {0,0,1}.
module tune_rom
    import audio_pkg::*;
#(
    parameter int NUM_TUNES = 4,
    parameter int TW        = 2
) (
    input  logic [TW-1:0] tune_id_i,
    input  logic [5:0]    note_idx_i,
    output note_t         note_o
);

    always_comb begin
        note_o = NOTE_END;
        if (int'(tune_id_i) < NUM_TUNES) begin
            case (int'(tune_id_i))
                0: if (note_idx_i < 6'(TUNE0_LEN)) note_o = TUNE0[note_idx_i[4:0]];
                1: if (note_idx_i < 6'(TUNE1_LEN)) note_o = TUNE1[note_idx_i[1:0]];
                2: if (note_idx_i < 6'(TUNE2_LEN)) note_o = TUNE2[note_idx_i[1:0]];
                3: if (note_idx_i < 6'(TUNE3_LEN)) note_o = TUNE3[note_idx_i[1:0]];
                default: note_o = NOTE_END;
            endcase
        end
    end

endmodule

// File: rtl/melody_player.sv
// Multi-tune square-wave sequencer: priority request arbitration, note timing in
// TICK_HZ ticks, optional inter-note gap, looping, stop and output-only mute.
module melody_player
    import audio_pkg::*;
#(
    parameter int  FCLK      = 50000000,
    parameter int  TICK_HZ   = 1000,
    parameter int  NUM_TUNES = 4,
    parameter int  GAP_TICKS = 0,
    localparam int TW        = (NUM_TUNES > 1) ? $clog2(NUM_TUNES) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_TUNES-1:0] play_req,
    input  logic                 loop_en,
    input  logic                 stop,
    input  logic                 mute,
    output logic                 spkr,
    output logic                 busy,
    output logic [TW-1:0]        tune_id,
    output logic [5:0]           note_idx,
    output logic                 done,
    output player_state_e        state_o
);

    localparam int DIV   = FCLK / TICK_HZ;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int ACC_W = $clog2(FCLK) + 2;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [ACC_W-1:0] FCLK_A   = ACC_W'(FCLK);
    localparam logic [15:0]      GAP_LAST = 16'(GAP_TICKS - 1);

    player_state_e    state_q;
    logic [TW-1:0]    tune_id_q;
    logic [5:0]       note_idx_q;
    logic [11:0]      freq_q;
    logic [15:0]      dur_q;
    logic             last_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [DIV_W-1:0] div_q;
    logic [15:0]      tick_q;
    logic             tone_q;
    logic             done_q;

    note_t            rom_note;
    logic [TW-1:0]    req_win;
    logic             req_take;
    logic [ACC_W-1:0] acc_sum;
    logic             tone_flip;
    logic             tick_end;

    tune_rom #(
        .NUM_TUNES (NUM_TUNES),
        .TW        (TW)
    ) u_rom (
        .tune_id_i  (tune_id_q),
        .note_idx_i (note_idx_q),
        .note_o     (rom_note)
    );

    // Highest set request bit wins; equal or higher priority may preempt.
    always_comb begin
        req_win = '0;
        for (int i = 0; i < NUM_TUNES; i++) begin
            if (play_req[i]) req_win = TW'(i);
        end
        req_take  = (|play_req) && (state_q == ST_IDLE || req_win >= tune_id_q);
        acc_sum   = acc_q + ACC_W'({freq_q, 1'b0});
        tone_flip = (acc_sum >= FCLK_A);
        acc_d     = tone_flip ? acc_sum - FCLK_A : acc_sum;
        tick_end  = (div_q == DIV_LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            tune_id_q  <= '0;
            note_idx_q <= '0;
            freq_q     <= '0;
            dur_q      <= '0;
            last_q     <= 1'b0;
            acc_q      <= '0;
            div_q      <= '0;
            tick_q     <= '0;
            tone_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (stop) begin
                state_q <= ST_IDLE;
                tone_q  <= 1'b0;
            end else if (req_take) begin
                tune_id_q  <= req_win;
                note_idx_q <= '0;
                tone_q     <= 1'b0;
                state_q    <= ST_LOAD;
            end else begin
                unique case (state_q)
                    ST_IDLE: ;
                    ST_LOAD: begin
                        freq_q <= rom_note.freq;
                        dur_q  <= rom_note.dur;
                        last_q <= rom_note.last;
                        acc_q  <= '0;
                        div_q  <= '0;
                        tick_q <= '0;
                        tone_q <= 1'b0;
                        if (rom_note.dur == 16'd0) begin
                            if (!rom_note.last) begin
                                note_idx_q <= note_idx_q + 6'd1;
                            end else if (loop_en) begin
                                note_idx_q <= '0;
                            end else begin
                                state_q <= ST_IDLE;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            state_q <= ST_PLAY;
                        end
                    end
                    ST_PLAY: begin
                        // A rest holds the accumulator so the tone stays silent.
                        if (freq_q != 12'd0) begin
                            acc_q <= acc_d;
                            if (tone_flip) tone_q <= ~tone_q;
                        end
                        div_q <= tick_end ? '0 : div_q + 1'b1;
                        if (tick_end) tick_q <= tick_q + 16'd1;
                        if (tick_end && tick_q == dur_q - 16'd1) begin
                            tone_q <= 1'b0;
                            div_q  <= '0;
                            tick_q <= '0;
                            if (!last_q) begin
                                if (GAP_TICKS > 0) begin
                                    state_q <= ST_GAP;
                                end else begin
                                    note_idx_q <= note_idx_q + 6'd1;
                                    state_q    <= ST_LOAD;
                                end
                            end else if (loop_en) begin
                                note_idx_q <= '0;
                                state_q    <= ST_LOAD;
                            end else begin
                                state_q <= ST_IDLE;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    ST_GAP: begin
                        div_q <= tick_end ? '0 : div_q + 1'b1;
                        if (tick_end) tick_q <= tick_q + 16'd1;
                        if (tick_end && tick_q == GAP_LAST) begin
                            note_idx_q <= note_idx_q + 6'd1;
                            state_q    <= ST_LOAD;
                        end
                    end
                endcase
            end
        end
    end

    // Mute gates only the pin; tone_q keeps its phase underneath.
    assign spkr     = tone_q & ~mute;
    assign busy     = (state_q != ST_IDLE);
    assign tune_id  = tune_id_q;
    assign note_idx = note_idx_q;
    assign done     = done_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_melody_player.sv
// Directed bench for melody_player at FCLK=100000 / TICK_HZ=1000 (100 cycles per tick),
// with a second instance using GAP_TICKS=2.
module tb_melody_player;
    import audio_pkg::*;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [3:0]    play_req = '0;
    logic          loop_en = 1'b0;
    logic          stop = 1'b0;
    logic          mute = 1'b0;
    logic          spkr, busy, done;
    logic [1:0]    tune_id;
    logic [5:0]    note_idx;
    player_state_e state;

    logic [3:0]    g_play_req = '0;
    logic          g_spkr, g_busy, g_done;
    logic [1:0]    g_tune_id;
    logic [5:0]    g_note_idx;
    player_state_e g_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    melody_player #(
        .FCLK(100000), .TICK_HZ(1000), .NUM_TUNES(4), .GAP_TICKS(0)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .play_req(play_req), .loop_en(loop_en),
        .stop(stop), .mute(mute), .spkr(spkr), .busy(busy), .tune_id(tune_id),
        .note_idx(note_idx), .done(done), .state_o(state)
    );

    melody_player #(
        .FCLK(100000), .TICK_HZ(1000), .NUM_TUNES(4), .GAP_TICKS(2)
    ) u_gap (
        .clk(clk), .reset_n(reset_n), .play_req(g_play_req), .loop_en(1'b0),
        .stop(1'b0), .mute(1'b0), .spkr(g_spkr), .busy(g_busy), .tune_id(g_tune_id),
        .note_idx(g_note_idx), .done(g_done), .state_o(g_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic pulse_req(input logic [3:0] r);
        play_req = r;
        @(negedge clk);
        play_req = '0;
    endtask

    initial begin
        int   cyc;
        int   tog;
        int   hits;
        logic prev;
        logic seen;

        // Reset values
        step();
        check("rst_spkr", 32'(spkr), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_tune_id", 32'(tune_id), 0);
        check("rst_note_idx", 32'(note_idx), 0);
        check("rst_done", 32'(done), 0);
        reset_n = 1'b1;
        repeat (2) step();

        // Tune 0, first note E5 for 500 ticks = 50000 cycles, ~659 toggles
        pulse_req(4'b0001);
        check("t0_busy_1cyc", 32'(busy), 1);
        check("t0_state_load", 32'(state), 32'(ST_LOAD));
        step();
        check("t0_state_play", 32'(state), 32'(ST_PLAY));
        cyc = 0; tog = 0; prev = 1'b0;
        while (state == ST_PLAY && note_idx == 6'd0 && cyc < 60000) begin
            cyc++;
            if (spkr !== prev) tog++;
            prev = spkr;
            step();
        end
        check("t0_note0_cycles", 32'(cyc), 50000);
        check("t0_note0_toggles_in_range", 32'(tog >= 658 && tog <= 660), 1);
        check("t0_load_gap_state", 32'(state), 32'(ST_LOAD));
        check("t0_load_gap_idx", 32'(note_idx), 1);
        check("t0_load_gap_spkr", 32'(spkr), 0);
        step();
        check("t0_note1_play", 32'(state), 32'(ST_PLAY));
        repeat (10) step();

        // Preempt with tune 1, then a lower-priority request is dropped
        pulse_req(4'b0010);
        check("pre_state_load", 32'(state), 32'(ST_LOAD));
        check("pre_tune_id", 32'(tune_id), 1);
        check("pre_note_idx", 32'(note_idx), 0);
        check("pre_spkr", 32'(spkr), 0);
        step();
        check("pre_state_play", 32'(state), 32'(ST_PLAY));
        repeat (5) step();
        pulse_req(4'b0001);
        check("low_req_tune_id", 32'(tune_id), 1);
        check("low_req_state", 32'(state), 32'(ST_PLAY));

        // Natural end of tune 1 without loop
        cyc = 0; hits = 0;
        while (busy && cyc < 3000) begin
            if (done) hits++;
            step();
            cyc++;
        end
        check("t1_end_busy", 32'(busy), 0);
        check("t1_done_with_fall", 32'(done), 1);
        check("t1_no_early_done", 32'(hits), 0);
        step();
        check("t1_done_one_cycle", 32'(done), 0);

        // Looping tune 1 wraps to note 0 without done
        loop_en = 1'b1;
        pulse_req(4'b0010);
        cyc = 0; hits = 0; seen = 1'b0;
        while (cyc < 3000) begin
            if (done) hits++;
            if (note_idx == 6'd2) seen = 1'b1;
            if (seen && note_idx == 6'd0) break;
            step();
            cyc++;
        end
        check("loop_wrapped", 32'(seen && note_idx == 6'd0), 1);
        check("loop_state_load", 32'(state), 32'(ST_LOAD));
        check("loop_busy", 32'(busy), 1);
        check("loop_no_done", 32'(hits), 0);

        // Stop wins over a same-cycle request
        stop = 1'b1;
        play_req = 4'b1000;
        step();
        stop = 1'b0;
        play_req = '0;
        loop_en = 1'b0;
        check("stop_busy", 32'(busy), 0);
        check("stop_spkr", 32'(spkr), 0);
        check("stop_state", 32'(state), 32'(ST_IDLE));
        check("stop_done", 32'(done), 0);
        check("stop_tune_id_held", 32'(tune_id), 1);
        step();
        check("stop_done_after", 32'(done), 0);

        // Tune 3: rest of 300 cycles, then zero-duration entry skipped in one LOAD
        pulse_req(4'b1000);
        check("t3_tune_id", 32'(tune_id), 3);
        cyc = 0;
        while (!(state == ST_PLAY && note_idx == 6'd1) && cyc < 1000) begin
            step();
            cyc++;
        end
        cyc = 0; hits = 0;
        while (state == ST_PLAY && note_idx == 6'd1 && cyc < 1000) begin
            if (spkr) hits++;
            step();
            cyc++;
        end
        check("rest_cycles", 32'(cyc), 300);
        check("rest_silent", 32'(hits), 0);
        check("skip_load_idx2", 32'(note_idx), 2);
        check("skip_load_state2", 32'(state), 32'(ST_LOAD));
        step();
        check("skip_load_idx3", 32'(note_idx), 3);
        check("skip_load_state3", 32'(state), 32'(ST_LOAD));
        step();
        check("skip_play_idx3", 32'(state), 32'(ST_PLAY));
        cyc = 0;
        while (busy && cyc < 1000) begin
            step();
            cyc++;
        end
        check("t3_done", 32'(done), 1);

        // Mute: pin silent, note schedule unchanged
        mute = 1'b1;
        pulse_req(4'b0010);
        check("mute_load", 32'(state), 32'(ST_LOAD));
        hits = 0;
        repeat (301) begin
            step();
            if (spkr) hits++;
        end
        check("mute_idx_on_time", 32'(note_idx), 1);
        check("mute_state_load", 32'(state), 32'(ST_LOAD));
        check("mute_silent", 32'(hits), 0);
        cyc = 0;
        while (busy && cyc < 2000) begin
            step();
            cyc++;
        end
        mute = 1'b0;
        step();

        // Asynchronous reset mid-note
        pulse_req(4'b0100);
        cyc = 0;
        while (!(note_idx == 6'd1 && spkr) && cyc < 1000) begin
            step();
            cyc++;
        end
        check("mid_note_spkr_high", 32'(spkr), 1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_spkr", 32'(spkr), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_tune_id", 32'(tune_id), 0);
        check("arst_note_idx", 32'(note_idx), 0);
        check("arst_done", 32'(done), 0);
        step();
        reset_n = 1'b1;
        step();

        // GAP_TICKS=2 instance: 200 silent cycles between notes
        g_play_req = 4'b0010;
        step();
        g_play_req = '0;
        step();
        check("gap_first_play", 32'(g_state), 32'(ST_PLAY));
        cyc = 0;
        while (g_state == ST_PLAY && g_note_idx == 6'd0 && cyc < 1000) begin
            step();
            cyc++;
        end
        check("gap_note0_cycles", 32'(cyc), 300);
        check("gap_state", 32'(g_state), 32'(ST_GAP));
        cyc = 0; hits = 0;
        while (g_state == ST_GAP && cyc < 1000) begin
            if (g_spkr) hits++;
            step();
            cyc++;
        end
        check("gap_cycles", 32'(cyc), 200);
        check("gap_silent", 32'(hits), 0);
        check("gap_then_load", 32'(g_state), 32'(ST_LOAD));
        check("gap_then_idx1", 32'(g_note_idx), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/melody_player.md
# melody_player

Multi-tune square-wave sequencer for the Tetris audio path. It replaces the single fixed game-over tone generator with a parametrised player. Several ROM-resident tunes (game over, line clear, level up, tetris) are selected by request pulses, with priority preemption, optional looping, mute, stop, a configurable inter-note gap and cycle-exact note durations. Game-logic event strobes drive it, and `spkr` goes to the board speaker pin.

## Interface
- `FCLK`, 50000000: clock frequency in Hz.
- `TICK_HZ`, 1000: duration tick rate. Note duration unit is 1/TICK_HZ s. FCLK % TICK_HZ == 0 is required.
- `NUM_TUNES`, 4: number of tunes, 1..8.
- `GAP_TICKS`, 0: silent ticks inserted between consecutive notes. 0 means no gap.
- `clk` in 1: system clock. One clock domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `play_req` in NUM_TUNES: one-hot-or-more start pulses. Bit i requests tune i.
- `loop_en` in 1: when high at tune end, the tune restarts at note 0.
- `stop` in 1: synchronous abort to idle.
- `mute` in 1: forces `spkr` low while sequencing continues.
- `spkr` out 1: square-wave output.
- `busy` out 1: high in any state other than IDLE.
- `tune_id` out $clog2(NUM_TUNES) (min 1): tune currently playing. Holds its last value when idle.
- `note_idx` out 6: index of the current note.
- `done` out 1: one-cycle pulse on natural completion of a tune.

## Operation
- States: IDLE, LOAD, PLAY, GAP.
- Reset values: `spkr`=0, `busy`=0, `tune_id`=0, `note_idx`=0, `done`=0. Accumulator, tick divider and tick counter are all 0.
- Request resolution: the highest set bit of `play_req` wins. The request is accepted when IDLE, or when the winning index is >= the current `tune_id` (preempt, or restart of the same tune). Lower-priority requests while busy are dropped. Accepting a request sets `tune_id`, sets `note_idx`=0 and goes to LOAD.
- `stop` has priority over `play_req` in the same cycle. It forces IDLE and `spkr`=0 and does not pulse `done`.
- LOAD (1 cycle): reads ROM entry {freq[11:0], dur[15:0], last} at (`tune_id`, `note_idx`).
  - Registers freq and dur.
  - Clears the accumulator and the tick divider, and sets `spkr`=0.
  - If dur==0, the note is skipped: if last, the tune ends; otherwise `note_idx`+1 and LOAD repeats.
  - Otherwise goes to PLAY.
- PLAY: the note lasts exactly dur×(FCLK/TICK_HZ) cycles, counted from the first PLAY cycle.
  - At expiry with last=0: go to GAP if GAP_TICKS>0, otherwise go straight to LOAD with `note_idx`+1.
  - At expiry with last=1, the tune ends.
- GAP: `spkr`=0 for GAP_TICKS×(FCLK/TICK_HZ) cycles, then LOAD with `note_idx`+1.
- Tune end: if `loop_en`=1, `note_idx`=0 and go to LOAD, with no `done`. Otherwise go to IDLE and pulse `done` in the same cycle `busy` falls.
- Tone generation: each PLAY cycle with freq≠0, s = acc + 2·freq.
  - If s >= FCLK: acc <= s − FCLK and `spkr` toggles.
  - Otherwise acc <= s.
- Rest: freq==0 keeps `spkr`=0 and the accumulator held.
- Widths:
  - freq is at most 4095 Hz, and 2·4095 < FCLK is required.
  - Accumulator is $clog2(FCLK)+2 bits, so no overflow.
  - `note_idx` wraps modulo 64; the ROM must terminate tunes with last=1 before index 63.
- `mute` gates only the output pin. Internal toggling continues, so the phase is preserved on unmute.

## Timing
- `play_req` sampled at edge N → `busy`=1 and state LOAD after edge N+1 → first PLAY cycle after N+2, and the first possible toggle is at edge N+3.
- Preemption follows the same 2-cycle path. `spkr` is 0 from LOAD onward.
- Note-to-note: 1 LOAD cycle of silence, not counted in any duration.
- `done` is a registered output, high exactly one cycle.
- `stop` takes effect at the next edge: `busy`=0 and `spkr`=0.
- Asserting `reset_n` mid-tune returns every output to its reset value immediately (asynchronously).

## Structure
- Package `audio_pkg`:
  - `note_t` packed struct {freq, dur, last}.
  - `player_state_e` enum.
  - Note-frequency localparams (A4=440, B4=494, C5=523, D5=587, E5=659, …).
  - Tune content as a constant `note_t` array per tune.
- Sub-module `tune_rom`: combinational lookup of (tune_id, note_idx) → `note_t`. Out-of-range lookups return {0,0,1}.
- Tune 0 is the existing 23-note game-over melody with freq 0 for rests. Tunes 1–3 are short (≤8 notes).

## Test plan
- FCLK=100000, TICK_HZ=1000, pulse `play_req`=0001 → `busy` high 1 cycle later. First note E5, dur 500, lasts exactly 50000 PLAY cycles. Measured toggle count ≈ 2·659·0.5 = 659 ±1.
- During tune 0, pulse `play_req`=0010 → tune 1 starts after 2 cycles and `tune_id`=1. Then pulse `play_req`=0001 during tune 1 → ignored.
- Same cycle `stop`=1 and `play_req`=1000 → IDLE next cycle, `spkr`=0, no `done`.
- Tune 1 with `loop_en`=0 → exactly one `done` pulse coincident with `busy` falling. With `loop_en`=1 → `note_idx` returns to 0, no `done`.
- ROM entry with freq=0 → `spkr` stays 0 for its full duration. ROM entry with dur=0 → skipped in one LOAD cycle. GAP_TICKS=2 → 200 silent cycles between notes.
- `reset_n` low mid-note → all outputs at reset values asynchronously. `mute`=1 → `spkr`=0 while `note_idx` keeps advancing on schedule.
